// File: rtl/vga_timing.sv
// 640x480@60 pixel-timing generator with a sync/blanking alignment stage that
// matches the renderer's registered colour back to the scan position it belongs to.
module vga_timing #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int CLK_DIV    = 2,
    parameter int PIPE_DELAY = 1
) (
    input  logic        CLK,
    input  logic        RST,
    output logic [31:0] row,
    output logic [31:0] col,
    output logic        vnotactive,
    output logic        pix_en,
    output logic        frame_start,
    input  logic        red_in,
    input  logic        green_in,
    input  logic        blue_in,
    output logic        hsync,
    output logic        vsync,
    output logic        vga_r,
    output logic        vga_g,
    output logic        vga_b
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = $clog2(CLK_DIV);

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hs: 1'b0, vs: 1'b0, blank: 1'b1};

    logic [DIV_W-1:0] div;
    logic [31:0]      col_next;
    logic [31:0]      row_next;
    logic             col_wrap;
    logic             row_wrap;
    logic             hs_raw;
    logic             vs_raw;
    sync_t            pipe [PIPE_DELAY];
    logic             red_s;
    logic             green_s;
    logic             blue_s;

    // NOTE: every signal gets a value at the top of always_comb so no path can infer a latch.
    always_comb begin
        col_wrap = (col == 32'(H_TOTAL - 1));
        row_wrap = (row == 32'(V_TOTAL - 1));
        col_next = col_wrap ? 32'd0 : col + 32'd1;
        row_next = row;
        if (col_wrap) begin
            row_next = row_wrap ? 32'd0 : row + 32'd1;
        end
        hs_raw = (col >= 32'(H_ACTIVE + H_FP)) && (col < 32'(H_ACTIVE + H_FP + H_SYNC));
        vs_raw = (row >= 32'(V_ACTIVE + V_FP)) && (row < 32'(V_ACTIVE + V_FP + V_SYNC));
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            div    <= '0;
            pix_en <= 1'b0;
        end else begin
            pix_en <= (div == DIV_W'(CLK_DIV - 1));
            div    <= (div == DIV_W'(CLK_DIV - 1)) ? '0 : div + 1'b1;
        end
    end

    // vnotactive is computed from the next position so it never lags row/col.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            col         <= '0;
            row         <= '0;
            vnotactive  <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_en) begin
            col         <= col_next;
            row         <= row_next;
            vnotactive  <= (col_next >= 32'(H_ACTIVE)) || (row_next >= 32'(V_ACTIVE));
            frame_start <= col_wrap && row_wrap;
        end else begin
            frame_start <= 1'b0;
        end
    end

    // NOTE: the delay line is only a few flops and must come out of reset blanked, so it is reset explicitly.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < PIPE_DELAY; i++) begin
                pipe[i] <= SYNC_IDLE;
            end
            red_s   <= 1'b0;
            green_s <= 1'b0;
            blue_s  <= 1'b0;
        end else if (pix_en) begin
            pipe[0] <= '{hs: hs_raw, vs: vs_raw, blank: vnotactive};
            for (int i = 1; i < PIPE_DELAY; i++) begin
                pipe[i] <= pipe[i-1];
            end
            red_s   <= red_in;
            green_s <= green_in;
            blue_s  <= blue_in;
        end
    end

    assign hsync = ~pipe[PIPE_DELAY-1].hs;
    assign vsync = ~pipe[PIPE_DELAY-1].vs;
    assign vga_r = red_s   & ~pipe[PIPE_DELAY-1].blank;
    assign vga_g = green_s & ~pipe[PIPE_DELAY-1].blank;
    assign vga_b = blue_s  & ~pipe[PIPE_DELAY-1].blank;

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench: a default 640x480 instance and a tiny-geometry instance that
// sweeps whole frames, both checked every cycle against an arithmetic scan model.
module tb_vga_timing;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;

    logic [31:0] row, col;
    logic        vnotactive, pix_en, frame_start, hsync, vsync, vga_r, vga_g, vga_b;
    logic        red_in = 1'b0, green_in = 1'b0, blue_in = 1'b0;

    logic [31:0] s_row, s_col;
    logic        s_vnotactive, s_pix_en, s_frame_start, s_hsync, s_vsync, s_vga_r, s_vga_g, s_vga_b;
    logic        s_red_in = 1'b0, s_green_in = 1'b0, s_blue_in = 1'b0;

    vga_timing dut (
        .CLK(CLK), .RST(RST), .row(row), .col(col), .vnotactive(vnotactive),
        .pix_en(pix_en), .frame_start(frame_start), .red_in(red_in),
        .green_in(green_in), .blue_in(blue_in), .hsync(hsync), .vsync(vsync),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
    );

    vga_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .CLK_DIV(3), .PIPE_DELAY(2)
    ) dut_s (
        .CLK(CLK), .RST(RST), .row(s_row), .col(s_col), .vnotactive(s_vnotactive),
        .pix_en(s_pix_en), .frame_start(s_frame_start), .red_in(s_red_in),
        .green_in(s_green_in), .blue_in(s_blue_in), .hsync(s_hsync), .vsync(s_vsync),
        .vga_r(s_vga_r), .vga_g(s_vga_g), .vga_b(s_vga_b)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          k;
        logic [31:0] row;
        logic [31:0] col;
        logic        pix_en;
        logic        hsync;
        logic        vnotactive;
    } vec_t;

    vec_t tbl [10];

    int n_checks = 0;
    int n_fail   = 0;
    int k        = 0;
    int gcyc     = 0;
    int ti       = 0;
    int hs_run   = 0;
    int vs_run   = 0;
    int last_fs  = -1;
    int r_hi     = 0;
    int fs_count = 0;
    logic sr = 1'b0, sg = 1'b0, sb = 1'b0;
    logic ssr = 1'b0, ssg = 1'b0, ssb = 1'b0;

    localparam logic [71:0] RESET_VEC = {32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (k=%0d): got %0h, expected %0h", name, k, act, exp);
        end
    endtask

    // True when the edge that produced cycle kk was a pixel-slot edge.
    function automatic bit adv(input int kk, input int cd);
        return (kk - 1 >= cd) && ((kk - 1) % cd == 0);
    endfunction

    // Scan state after kk edges since reset release, from plain slot arithmetic.
    function automatic logic [71:0] model(input int kk, input int cd, input int pd,
                                          input int ha, input int hf, input int hsw, input int hb,
                                          input int va, input int vf, input int vsw, input int vb,
                                          input logic cr, input logic cg, input logic cb);
        int ht, vt, n, c, r, m, dc, dr;
        logic pe, fs, vna, hs, vs, blank;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        n  = (kk == 0) ? 0 : (kk - 1) / cd;
        c  = n % ht;
        r  = (n / ht) % vt;
        pe = (kk >= cd) && (kk % cd == 0);
        fs = adv(kk, cd) && (n % (ht * vt) == 0);
        vna = (c >= ha) || (r >= va);
        hs = 1'b1; vs = 1'b1; blank = 1'b1;
        m  = n - pd;
        if (m >= 0) begin
            dc    = m % ht;
            dr    = (m / ht) % vt;
            hs    = !((dc >= ha + hf) && (dc < ha + hf + hsw));
            vs    = !((dr >= va + vf) && (dr < va + vf + vsw));
            blank = (dc >= ha) || (dr >= va);
        end
        return {32'(r), 32'(c), vna, pe, fs, hs, vs, cr & !blank, cg & !blank, cb & !blank};
    endfunction

    function automatic logic [71:0] obs_d();
        return {row, col, vnotactive, pix_en, frame_start, hsync, vsync, vga_r, vga_g, vga_b};
    endfunction

    function automatic logic [71:0] obs_s();
        return {s_row, s_col, s_vnotactive, s_pix_en, s_frame_start, s_hsync, s_vsync, s_vga_r, s_vga_g, s_vga_b};
    endfunction

    // Phase 1: constant white. Phase 2: a renderer that lights red only at (0,0).
    task automatic drive(input bit phase2);
        int n;
        n = (k == 0) ? 0 : (k - 1) / 2;
        if (phase2) begin
            red_in   = (n % 800 == 0) && ((n / 800) % 525 == 0);
            green_in = 1'($urandom);
            blue_in  = 1'($urandom);
        end else begin
            red_in = 1'b1; green_in = 1'b1; blue_in = 1'b1;
        end
        s_red_in   = 1'($urandom);
        s_green_in = 1'($urandom);
        s_blue_in  = 1'($urandom);
    endtask

    task automatic check_models();
        check("dflt_scan", 128'(obs_d()), 128'(model(k, 2, 1, 640, 16, 96, 48, 480, 10, 2, 33, sr, sg, sb)));
        check("small_scan", 128'(obs_s()), 128'(model(k, 3, 2, 8, 2, 3, 3, 6, 1, 2, 2, ssr, ssg, ssb)));
    endtask

    task automatic step(input bit phase2);
        @(negedge CLK);
        k++;
        gcyc++;
        if (adv(k, 2)) begin sr = red_in; sg = green_in; sb = blue_in; end
        if (adv(k, 3)) begin ssr = s_red_in; ssg = s_green_in; ssb = s_blue_in; end
        check_models();
        if (!phase2 && ti < 10 && tbl[ti].k == k) begin
            check("dflt_table", {61'd0, row, col, pix_en, hsync, vnotactive},
                  {61'd0, tbl[ti].row, tbl[ti].col, tbl[ti].pix_en, tbl[ti].hsync, tbl[ti].vnotactive});
            ti++;
        end
        if (hsync == 1'b0) hs_run++;
        else begin
            if (hs_run > 0) check("hsync_low_cycles", 128'(hs_run), 128'(192));
            hs_run = 0;
        end
        if (s_vsync == 1'b0) vs_run++;
        else begin
            if (vs_run > 0) check("small_vsync_low_cycles", 128'(vs_run), 128'(96));
            vs_run = 0;
        end
        if (s_frame_start) begin
            if (last_fs >= 0) check("small_frame_period", 128'(gcyc - last_fs), 128'(528));
            last_fs = gcyc;
            fs_count++;
        end
        if (phase2 && vga_r) r_hi++;
        drive(phase2);
    endtask

    initial begin
        tbl[0] = '{k: 0,    row: 0, col: 0,   pix_en: 0, hsync: 1, vnotactive: 0};
        tbl[1] = '{k: 2,    row: 0, col: 0,   pix_en: 1, hsync: 1, vnotactive: 0};
        tbl[2] = '{k: 3,    row: 0, col: 1,   pix_en: 0, hsync: 1, vnotactive: 0};
        tbl[3] = '{k: 1281, row: 0, col: 640, pix_en: 0, hsync: 1, vnotactive: 1};
        tbl[4] = '{k: 1313, row: 0, col: 656, pix_en: 0, hsync: 1, vnotactive: 1};
        tbl[5] = '{k: 1315, row: 0, col: 657, pix_en: 0, hsync: 0, vnotactive: 1};
        tbl[6] = '{k: 1505, row: 0, col: 752, pix_en: 0, hsync: 0, vnotactive: 1};
        tbl[7] = '{k: 1507, row: 0, col: 753, pix_en: 0, hsync: 1, vnotactive: 1};
        tbl[8] = '{k: 1601, row: 1, col: 0,   pix_en: 0, hsync: 1, vnotactive: 0};
        tbl[9] = '{k: 1602, row: 1, col: 0,   pix_en: 1, hsync: 1, vnotactive: 0};

        repeat (3) @(negedge CLK);
        check("reset_dflt", 128'(obs_d()), 128'(RESET_VEC));
        check_models();
        check("dflt_table", {61'd0, row, col, pix_en, hsync, vnotactive},
              {61'd0, tbl[0].row, tbl[0].col, tbl[0].pix_en, tbl[0].hsync, tbl[0].vnotactive});
        ti = 1;
        RST = 1'b1;
        drive(1'b0);

        while (k < 3001) step(1'b0);
        check("hsync_low_before_reset", 128'(hsync), 128'(0));
        check("small_frames_seen", 128'(fs_count >= 5), 128'(1));

        // Asynchronous reset in the middle of a clock phase, during an hsync pulse.
        #2 RST = 1'b0;
        #1;
        check("async_reset_dflt", 128'(obs_d()), 128'(RESET_VEC));
        check("async_reset_small", 128'(obs_s()), 128'(RESET_VEC));
        repeat (2) @(negedge CLK);
        k = 0; sr = 0; sg = 0; sb = 0; ssr = 0; ssg = 0; ssb = 0;
        hs_run = 0; vs_run = 0; last_fs = -1;
        check_models();
        RST = 1'b1;
        drive(1'b1);

        while (k < 2000) step(1'b1);
        check("align_red_cycles", 128'(r_hi), 128'(2));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing.md
# vga_timing

Pixel-timing generator and video output stage for the 640x480@60 board display. It produces the `row`/`col` scan position and the `vnotactive` blanking flag consumed by the board renderer, then samples the renderer's registered `red`/`green`/`blue` back in. Sync pulses are delayed to match the renderer's latency, and colour is forced to black outside the active area before it drives the VGA connector.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, CLK cycles per pixel; legal range 2..16
- PIPE_DELAY, 1, pixel slots between a position update and the matching RGB sample; legal range 1..4

Ports:
- CLK  in  1  system clock
- RST  in  1  reset: RST, asynchronous, active-low; clock CLK.
- row  out  32  current line, 0..V_TOTAL-1 (upper bits zero)
- col  out  32  current pixel in line, 0..H_TOTAL-1 (upper bits zero)
- vnotactive  out  1  1 when (row,col) is outside the active area
- pix_en  out  1  one-CLK strobe marking each pixel slot
- frame_start  out  1  one-CLK pulse when position wraps to (0,0)
- red_in, green_in, blue_in  in  1 each  renderer colour for the current position
- hsync, vsync  out  1 each  sync outputs, active-low
- vga_r, vga_g, vga_b  out  1 each  colour to the connector

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Divider: counter 0..CLK_DIV-1. `pix_en` is registered high for exactly the one cycle after the counter equals CLK_DIV-1.
- Position counters:
  - Advance only on CLK edges where `pix_en`=1.
  - `col` wraps at H_TOTAL-1 to 0. `row` increments on a `col` wrap and wraps at V_TOTAL-1 to 0.
  - `frame_start`=1 for the single cycle in which (row,col) becomes (0,0) by wrap, never on reset.
- `vnotactive` = (col >= H_ACTIVE) | (row >= V_ACTIVE). It is registered together with row/col and always consistent with them.
- Raw sync:
  - hs_raw active when H_ACTIVE+H_FP <= col < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vs_raw active when V_ACTIVE+V_FP <= row < V_ACTIVE+V_FP+V_SYNC (490..491).
- Alignment pipeline:
  - Shift register of depth PIPE_DELAY carrying {hs_raw, vs_raw, vnotactive}, advanced on `pix_en`.
  - On each `pix_en` edge, `red_in`/`green_in`/`blue_in` are sampled. They reflect the position presented one pixel slot earlier, which is valid because CLK_DIV >= 2 gives the renderer at least one CLK to register.
  - `vga_*` = sampled colour AND NOT (delayed vnotactive). `hsync`/`vsync` = NOT (delayed raw sync).
- The renderer's own colour logic is not re-checked: any value outside the active area is blanked regardless.

## Timing
- Reset values: row=0, col=0, vnotactive=0, pix_en=0, frame_start=0, hsync=1, vsync=1, vga_r/g/b=0. Divider=0; pipeline filled with {inactive sync, vnotactive=1}.
- First `pix_en` comes CLK_DIV cycles after RST deasserts. The first position advance (to col=1) occurs on that edge.
- Output latency: hsync/vsync/vga_* for position P appear PIPE_DELAY pixel slots after P is presented on row/col.
- Line period is H_TOTAL×CLK_DIV CLKs. Frame period is V_TOTAL×H_TOTAL×CLK_DIV CLKs.
- Reset asserted mid-frame: all outputs take their reset values asynchronously, with no partial sync pulse held. Scanning restarts at (0,0).
- Simultaneous col wrap and row wrap: both counters go to 0 in the same cycle and `frame_start` pulses in that same cycle.
- `red_in`/`green_in`/`blue_in` changing between `pix_en` strobes has no effect on outputs.

## Test plan
- Defaults, run 2 lines: `pix_en` every 2nd CLK; `col` 0..799 then 0; `row` increments once per 1600 CLKs.
- Hsync shape: `hsync` low for exactly 96 pix_en slots, starting at the slot after `col`=656 is presented (PIPE_DELAY=1); high otherwise.
- Full frame: `vsync` low for 2 lines starting one slot after (490,0); `frame_start` pulses once per 840000 CLKs, when row=col=0.
- Blanking: drive `red_in`=`green_in`=`blue_in`=1 constantly -> `vga_*`=1 only in the delayed active region; 0 during cols 640..799 and rows 480..524.
- Alignment: drive `red_in`=1 only when the previous position was col=0, row=0 -> `vga_r`=1 for exactly one slot, coincident with delayed vnotactive=0 at (0,0).
- Reset mid-frame at (300,700): outputs return to reset values immediately. After release, the first `pix_en` is 2 CLKs later and scanning resumes from (0,1) with no spurious `frame_start`.
